// File: rtl/crosshair_pkg.sv
// Shared state encoding, object codes, screen limits and reset positions for the
// crosshair manual-calibration controller and its per-axis repeat helper.
package crosshair_pkg;

  typedef enum logic [1:0] {
    AUTO     = 2'd0,
    ADJ_PUCK = 2'd1,
    ADJ_PAD1 = 2'd2,
    ADJ_PAD2 = 2'd3
  } calib_state_e;

  localparam logic [1:0] OBJ_PUCK = 2'd0;
  localparam logic [1:0] OBJ_PAD1 = 2'd1;
  localparam logic [1:0] OBJ_PAD2 = 2'd2;

  localparam int H_VISIBLE = 1024;
  localparam int V_VISIBLE = 768;

  localparam logic [10:0] PUCK_X_RST = 11'd512;
  localparam logic [9:0]  PUCK_Y_RST = 10'd384;
  localparam logic [10:0] PAD1_X_RST = 11'd128;
  localparam logic [9:0]  PAD1_Y_RST = 10'd384;
  localparam logic [10:0] PAD2_X_RST = 11'd896;
  localparam logic [9:0]  PAD2_Y_RST = 10'd384;

  // 12-bit arithmetic so val+step can exceed the limit before saturating; never wraps.
  function automatic logic [11:0] step_clamp(input logic [11:0] val,
                                             input logic        inc,
                                             input logic        dec,
                                             input logic [11:0] step,
                                             input logic [11:0] max_val);
    logic [11:0] sum;
    logic [11:0] res;
    sum = val + step;
    res = val;
    if (inc && !dec) begin
      res = (sum > max_val) ? max_val : sum;
    end else if (dec && !inc) begin
      res = (val < step) ? 12'd0 : (val - step);
    end
    return res;
  endfunction

  function automatic logic [11:0] clamp_max(input logic [11:0] val,
                                            input logic [11:0] max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/calib_axis_repeat.sv
// Per-axis press/hold tracker: turns two opposing direction buttons into single-cycle
// inc/dec move pulses on the frame tick, with initial-press move plus delayed auto-repeat.
module calib_axis_repeat
  import crosshair_pkg::*;
#(
  parameter int RPT_DELAY = 20,
  parameter int RPT_RATE  = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic clear,
  input  logic btn_inc,
  input  logic btn_dec,
  output logic move_inc,
  output logic move_dec
);

  localparam int CNT_TOP = RPT_DELAY + RPT_RATE;
  localparam int CW      = $clog2(CNT_TOP + 1);
  localparam logic [CW-1:0] CNT_TOP_C   = CW'(CNT_TOP);
  localparam logic [CW-1:0] RPT_DELAY_C = CW'(RPT_DELAY);

  logic [CW-1:0] hold_cnt;
  logic [CW-1:0] hold_cnt_next;
  logic [CW-1:0] cnt_plus;
  logic          prev_inc;
  logic          prev_dec;
  logic          locked;
  logic          single;
  logic          fresh;
  logic          rpt_hit;
  logic          move_ok;

  // Counter wraps from DELAY+RATE back to DELAY so repeats stay periodic without a divider.
  always_comb begin
    single        = btn_inc ^ btn_dec;
    fresh         = (btn_inc && !prev_inc) || (btn_dec && !prev_dec);
    cnt_plus      = hold_cnt + 1'b1;
    hold_cnt_next = hold_cnt;
    rpt_hit       = 1'b0;
    if (!single || locked || fresh) begin
      hold_cnt_next = '0;
    end else if (cnt_plus == CNT_TOP_C) begin
      hold_cnt_next = RPT_DELAY_C;
      rpt_hit       = 1'b1;
    end else begin
      hold_cnt_next = cnt_plus;
      rpt_hit       = (cnt_plus == RPT_DELAY_C);
    end
    move_ok  = tick && single && !locked && (fresh || rpt_hit);
    move_inc = move_ok && btn_inc;
    move_dec = move_ok && btn_dec;
  end

  // After an object switch the axis stays locked until both buttons are released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
      prev_inc <= 1'b0;
      prev_dec <= 1'b0;
      locked   <= 1'b0;
    end else begin
      if (tick) begin
        prev_inc <= btn_inc;
        prev_dec <= btn_dec;
      end
      if (clear) begin
        hold_cnt <= '0;
        locked   <= 1'b1;
      end else begin
        if (!btn_inc && !btn_dec) begin
          locked <= 1'b0;
        end
        if (tick) begin
          hold_cnt <= hold_cnt_next;
        end
      end
    end
  end

endmodule

// File: rtl/crosshair_calib_ctrl.sv
// Manual-adjust controller for the crosshair overlay: button-driven object walk and per-frame
// clamped moves. Optional macro CALIB_SNAPSHOT_EN seeds manual coordinates from detected centers.
module crosshair_calib_ctrl
  import crosshair_pkg::*;
#(
  parameter int H_MAX     = H_VISIBLE - 1,
  parameter int V_MAX     = V_VISIBLE - 1,
  parameter int STEP      = 2,
  parameter int RPT_DELAY = 20,
  parameter int RPT_RATE  = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        sw_manual,
  input  logic        btn_sel,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic [10:0] x_center_puck,
  input  logic [9:0]  y_center_puck,
  input  logic [10:0] x_center_paddle1,
  input  logic [9:0]  y_center_paddle1,
  input  logic [10:0] x_center_paddle2,
  input  logic [9:0]  y_center_paddle2,
  output logic        center_sel,
  output logic [1:0]  obj_sel,
  output logic [10:0] x_new_puck,
  output logic [10:0] x_new_paddle1,
  output logic [10:0] x_new_paddle2,
  output logic [9:0]  y_new_puck,
  output logic [9:0]  y_new_paddle1,
  output logic [9:0]  y_new_paddle2
);

  localparam logic [11:0] H_MAX_C = 12'(H_MAX);
  localparam logic [11:0] V_MAX_C = 12'(V_MAX);
  localparam logic [11:0] STEP_C  = 12'(STEP);

  calib_state_e state;
  calib_state_e state_next;
  logic         btn_sel_q;
  logic         sel_edge;
  logic         tick;
  logic         axis_clear;
  logic         center_sel_d;
  logic [1:0]   obj_sel_d;
  logic         move_x_inc;
  logic         move_x_dec;
  logic         move_y_inc;
  logic         move_y_dec;
  logic         move_any;
  logic [11:0]  x_cur;
  logic [11:0]  y_cur;
  logic [11:0]  x_next;
  logic [11:0]  y_next;
  logic         unused_step_msbs;

  assign tick       = (hcount == 11'd0) && (vcount == 10'd0);
  assign sel_edge   = btn_sel && !btn_sel_q;
  assign axis_clear = (state_next != state);
  assign move_any   = move_x_inc | move_x_dec | move_y_inc | move_y_dec;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= AUTO;
    end else begin
      state <= state_next;
    end
  end

  // Dropping out of manual mode wins over a simultaneous select press.
  always_comb begin
    state_next = state;
    case (state)
      AUTO:     if (sw_manual) state_next = ADJ_PUCK;
      ADJ_PUCK: if (!sw_manual) state_next = AUTO;
                else if (sel_edge) state_next = ADJ_PAD1;
      ADJ_PAD1: if (!sw_manual) state_next = AUTO;
                else if (sel_edge) state_next = ADJ_PAD2;
      ADJ_PAD2: if (!sw_manual) state_next = AUTO;
                else if (sel_edge) state_next = ADJ_PUCK;
      default:  state_next = AUTO;
    endcase
  end

  always_comb begin
    center_sel_d = (state != AUTO);
    obj_sel_d    = OBJ_PUCK;
    case (state)
      ADJ_PAD1: obj_sel_d = OBJ_PAD1;
      ADJ_PAD2: obj_sel_d = OBJ_PAD2;
      default:  obj_sel_d = OBJ_PUCK;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      center_sel <= 1'b0;
      obj_sel    <= OBJ_PUCK;
      btn_sel_q  <= 1'b0;
    end else begin
      center_sel <= center_sel_d;
      obj_sel    <= obj_sel_d;
      btn_sel_q  <= btn_sel;
    end
  end

  calib_axis_repeat #(
    .RPT_DELAY (RPT_DELAY),
    .RPT_RATE  (RPT_RATE)
  ) u_axis_x (
    .clk      (clk),
    .reset_n  (reset_n),
    .tick     (tick),
    .clear    (axis_clear),
    .btn_inc  (btn_right),
    .btn_dec  (btn_left),
    .move_inc (move_x_inc),
    .move_dec (move_x_dec)
  );

  // Screen y grows downward, so "up" is the decrementing direction.
  calib_axis_repeat #(
    .RPT_DELAY (RPT_DELAY),
    .RPT_RATE  (RPT_RATE)
  ) u_axis_y (
    .clk      (clk),
    .reset_n  (reset_n),
    .tick     (tick),
    .clear    (axis_clear),
    .btn_inc  (btn_down),
    .btn_dec  (btn_up),
    .move_inc (move_y_inc),
    .move_dec (move_y_dec)
  );

  always_comb begin
    x_cur = {1'b0, x_new_puck};
    y_cur = {2'b00, y_new_puck};
    case (obj_sel)
      OBJ_PAD1: begin
        x_cur = {1'b0, x_new_paddle1};
        y_cur = {2'b00, y_new_paddle1};
      end
      OBJ_PAD2: begin
        x_cur = {1'b0, x_new_paddle2};
        y_cur = {2'b00, y_new_paddle2};
      end
      default: ;
    endcase
    x_next = step_clamp(x_cur, move_x_inc, move_x_dec, STEP_C, H_MAX_C);
    y_next = step_clamp(y_cur, move_y_inc, move_y_dec, STEP_C, V_MAX_C);
  end

  assign unused_step_msbs = x_next[11] ^ y_next[11] ^ y_next[10];

`ifdef CALIB_SNAPSHOT_EN
  logic snap_load;
  assign snap_load = (state == AUTO) && (state_next == ADJ_PUCK);
`else
  logic unused_centers;
  assign unused_centers = ^{x_center_puck, y_center_puck, x_center_paddle1,
                            y_center_paddle1, x_center_paddle2, y_center_paddle2};
`endif

  // Moves land only on the tick edge and only for the object the overlay is showing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_new_puck    <= PUCK_X_RST;
      y_new_puck    <= PUCK_Y_RST;
      x_new_paddle1 <= PAD1_X_RST;
      y_new_paddle1 <= PAD1_Y_RST;
      x_new_paddle2 <= PAD2_X_RST;
      y_new_paddle2 <= PAD2_Y_RST;
    end
`ifdef CALIB_SNAPSHOT_EN
    else if (snap_load) begin
      x_new_puck    <= 11'(clamp_max({1'b0, x_center_puck}, H_MAX_C));
      y_new_puck    <= 10'(clamp_max({2'b00, y_center_puck}, V_MAX_C));
      x_new_paddle1 <= 11'(clamp_max({1'b0, x_center_paddle1}, H_MAX_C));
      y_new_paddle1 <= 10'(clamp_max({2'b00, y_center_paddle1}, V_MAX_C));
      x_new_paddle2 <= 11'(clamp_max({1'b0, x_center_paddle2}, H_MAX_C));
      y_new_paddle2 <= 10'(clamp_max({2'b00, y_center_paddle2}, V_MAX_C));
    end
`endif
    else if (center_sel && move_any) begin
      case (obj_sel)
        OBJ_PUCK: begin
          x_new_puck <= x_next[10:0];
          y_new_puck <= y_next[9:0];
        end
        OBJ_PAD1: begin
          x_new_paddle1 <= x_next[10:0];
          y_new_paddle1 <= y_next[9:0];
        end
        OBJ_PAD2: begin
          x_new_paddle2 <= x_next[10:0];
          y_new_paddle2 <= y_next[9:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crosshair_calib_ctrl.sv
// Self-checking bench for crosshair_calib_ctrl: a short raster drives frame ticks, expected
// output values are queued as stimulus is applied and compared when the frame has landed.
module tb_crosshair_calib_ctrl;

  localparam int H_TOTAL = 8;
  localparam int V_TOTAL = 4;
  localparam int FRAME   = H_TOTAL * V_TOTAL;

  localparam int SIG_CSEL = 0;
  localparam int SIG_OBJ  = 1;
  localparam int SIG_XP   = 2;
  localparam int SIG_YP   = 3;
  localparam int SIG_X1   = 4;
  localparam int SIG_Y1   = 5;
  localparam int SIG_X2   = 6;
  localparam int SIG_Y2   = 7;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] hcount = 11'd0;
  logic [9:0]  vcount = 10'd0;
  logic        sw_manual = 1'b0;
  logic        btn_sel = 1'b0;
  logic        btn_up = 1'b0;
  logic        btn_down = 1'b0;
  logic        btn_left = 1'b0;
  logic        btn_right = 1'b0;
  logic [10:0] x_center_puck = 11'd512;
  logic [9:0]  y_center_puck = 10'd384;
  logic [10:0] x_center_paddle1 = 11'd128;
  logic [9:0]  y_center_paddle1 = 10'd384;
  logic [10:0] x_center_paddle2 = 11'd896;
  logic [9:0]  y_center_paddle2 = 10'd384;
  logic        center_sel;
  logic [1:0]  obj_sel;
  logic [10:0] x_new_puck;
  logic [10:0] x_new_paddle1;
  logic [10:0] x_new_paddle2;
  logic [9:0]  y_new_puck;
  logic [9:0]  y_new_paddle1;
  logic [9:0]  y_new_paddle2;

  int tests_run = 0;
  int tests_failed = 0;
  int tick_count = 0;

  typedef struct {
    string tag;
    int    sig;
    int    value;
  } expect_t;

  expect_t exp_q[$];

  crosshair_calib_ctrl dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .hcount           (hcount),
    .vcount           (vcount),
    .sw_manual        (sw_manual),
    .btn_sel          (btn_sel),
    .btn_up           (btn_up),
    .btn_down         (btn_down),
    .btn_left         (btn_left),
    .btn_right        (btn_right),
    .x_center_puck    (x_center_puck),
    .y_center_puck    (y_center_puck),
    .x_center_paddle1 (x_center_paddle1),
    .y_center_paddle1 (y_center_paddle1),
    .x_center_paddle2 (x_center_paddle2),
    .y_center_paddle2 (y_center_paddle2),
    .center_sel       (center_sel),
    .obj_sel          (obj_sel),
    .x_new_puck       (x_new_puck),
    .x_new_paddle1    (x_new_paddle1),
    .x_new_paddle2    (x_new_paddle2),
    .y_new_puck       (y_new_puck),
    .y_new_paddle1    (y_new_paddle1),
    .y_new_paddle2    (y_new_paddle2)
  );

  always #5 clk = ~clk;

  // Raster advances on the falling edge so the DUT sees stable counts at the rising edge.
  always @(negedge clk) begin
    if (hcount == 11'(H_TOTAL - 1)) begin
      hcount = 11'd0;
      vcount = (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;
    end else begin
      hcount = hcount + 11'd1;
    end
  end

  always @(posedge clk) begin
    if (hcount == 11'd0 && vcount == 10'd0) tick_count = tick_count + 1;
  end

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      SIG_CSEL: observe = {31'd0, center_sel};
      SIG_OBJ:  observe = {30'd0, obj_sel};
      SIG_XP:   observe = {21'd0, x_new_puck};
      SIG_YP:   observe = {22'd0, y_new_puck};
      SIG_X1:   observe = {21'd0, x_new_paddle1};
      SIG_Y1:   observe = {22'd0, y_new_paddle1};
      SIG_X2:   observe = {21'd0, x_new_paddle2};
      default:  observe = {22'd0, y_new_paddle2};
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input int expected);
    tests_run = tests_run + 1;
    if (observed !== 32'(expected)) begin
      tests_failed = tests_failed + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic void expectVal(input string tag, input int sig, input int value);
    expect_t e;
    e.tag   = tag;
    e.sig   = sig;
    e.value = value;
    exp_q.push_back(e);
  endfunction

  function automatic void expectAll(input string tag, input int xp, input int yp,
                                    input int x1, input int y1, input int x2, input int y2);
    expectVal({tag, "_xp"}, SIG_XP, xp);
    expectVal({tag, "_yp"}, SIG_YP, yp);
    expectVal({tag, "_x1"}, SIG_X1, x1);
    expectVal({tag, "_y1"}, SIG_Y1, y1);
    expectVal({tag, "_x2"}, SIG_X2, x2);
    expectVal({tag, "_y2"}, SIG_Y2, y2);
  endfunction

  task automatic drainScoreboard();
    expect_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput(e.tag, observe(e.sig), e.value);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitFrames(input int n);
    int target;
    int budget;
    target = tick_count + n;
    budget = n * FRAME + 64;
    while (tick_count < target && budget > 0) begin
      @(negedge clk);
      budget = budget - 1;
    end
    if (tick_count < target) checkOutput("frame_wait", 32'(tick_count), target);
    waitCycles(2);
  endtask

  // Holds the given buttons across n frame ticks, then releases for one idle frame.
  task automatic applyStimulus(input logic up, input logic down, input logic left,
                               input logic right, input int frames);
    btn_up    = up;
    btn_down  = down;
    btn_left  = left;
    btn_right = right;
    waitFrames(frames);
    btn_up    = 1'b0;
    btn_down  = 1'b0;
    btn_left  = 1'b0;
    btn_right = 1'b0;
    waitFrames(1);
  endtask

  task automatic pulseSel();
    btn_sel = 1'b1;
    waitCycles(2);
    btn_sel = 1'b0;
    waitCycles(2);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    waitCycles(3);
    expectVal("reset_csel", SIG_CSEL, 0);
    expectVal("reset_obj", SIG_OBJ, 0);
    expectAll("reset", 512, 384, 128, 384, 896, 384);
    drainScoreboard();
    reset_n = 1'b1;
    waitCycles(3);

    sw_manual = 1'b1;
    waitFrames(1);
    expectVal("manual_csel", SIG_CSEL, 1);
    expectVal("manual_obj", SIG_OBJ, 0);
    drainScoreboard();

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1);
    expectAll("right_tap", 514, 384, 128, 384, 896, 384);
    drainScoreboard();

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 30);
    expectVal("up_hold_yp", SIG_YP, 374);
    expectVal("up_hold_xp", SIG_XP, 514);
    drainScoreboard();

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3);
    expectVal("opposed_xp", SIG_XP, 514);
    expectVal("opposed_yp", SIG_YP, 374);
    drainScoreboard();

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1);
    expectVal("diag_xp", SIG_XP, 512);
    expectVal("diag_yp", SIG_YP, 376);
    drainScoreboard();

    pulseSel();
    expectVal("sel1_obj", SIG_OBJ, 1);
    drainScoreboard();
    for (int i = 0; i < 63; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1);
    expectAll("pad1_left", 512, 376, 2, 384, 896, 384);
    drainScoreboard();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1);
    expectVal("pad1_zero", SIG_X1, 0);
    drainScoreboard();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1);
    expectVal("pad1_floor", SIG_X1, 0);
    drainScoreboard();

    pulseSel();
    expectVal("sel2_obj", SIG_OBJ, 2);
    drainScoreboard();
    for (int i = 0; i < 63; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1);
    expectVal("pad2_1022", SIG_X2, 1022);
    drainScoreboard();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1);
    expectVal("pad2_max", SIG_X2, 1023);
    drainScoreboard();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1);
    expectAll("pad2_ceiling", 512, 376, 0, 384, 1023, 384);
    drainScoreboard();

    pulseSel();
    expectVal("sel_wrap_obj", SIG_OBJ, 0);
    drainScoreboard();
    pulseSel();
    expectVal("sel_again_obj", SIG_OBJ, 1);
    drainScoreboard();

    btn_left = 1'b1;
    waitFrames(2);
    pulseSel();
    waitFrames(25);
    expectVal("switch_obj", SIG_OBJ, 2);
    expectVal("switch_hold_x2", SIG_X2, 1023);
    expectVal("switch_hold_x1", SIG_X1, 0);
    drainScoreboard();
    btn_left = 1'b0;
    waitFrames(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1);
    expectVal("fresh_press_x2", SIG_X2, 1021);
    drainScoreboard();

    sw_manual = 1'b0;
    btn_sel   = 1'b1;
    waitCycles(3);
    btn_sel   = 1'b0;
    expectVal("auto_csel", SIG_CSEL, 0);
    expectVal("auto_obj", SIG_OBJ, 0);
    drainScoreboard();
    x_center_puck    = 11'd300;
    y_center_puck    = 10'd200;
    x_center_paddle1 = 11'd2000;
    y_center_paddle1 = 10'd900;
    x_center_paddle2 = 11'd5;
    y_center_paddle2 = 10'd6;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1);
    expectAll("auto_frozen", 512, 376, 0, 384, 1021, 384);
    drainScoreboard();

    sw_manual = 1'b1;
    waitCycles(3);
    expectVal("reenter_csel", SIG_CSEL, 1);
    expectVal("reenter_obj", SIG_OBJ, 0);
`ifdef CALIB_SNAPSHOT_EN
    expectAll("snapshot", 300, 200, 1023, 767, 5, 6);
`else
    expectAll("persist", 512, 376, 0, 384, 1021, 384);
`endif
    drainScoreboard();

    btn_up = 1'b1;
    waitFrames(3);
    waitCycles(5);
    reset_n = 1'b0;
    #1;
    expectVal("midreset_csel", SIG_CSEL, 0);
    expectVal("midreset_obj", SIG_OBJ, 0);
    expectAll("midreset", 512, 384, 128, 384, 896, 384);
    drainScoreboard();
    btn_up = 1'b0;
    waitCycles(2);
    reset_n = 1'b1;
    waitCycles(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
